// File: rtl/uart_pkg.sv
// Shared types and helpers for the 8N1 UART transceiver.
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_REC_BYTE,
        RX_STOP,
        RX_DATA
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_SEND_BYTE,
        TX_STOP
    } tx_state_t;

    // Clocks per serial bit, truncated.
    function automatic int bit_cycles(input int clk_mhz, input int baud);
        return (clk_mhz * 1_000_000) / baud;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..CYCLE-1, strobes mid/end of each bit and tracks the bit index.
module uart_bit_timer #(
    parameter int CYCLE = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       bit_en,
    output logic       mid_bit,
    output logic       end_bit,
    output logic [2:0] bit_idx
);

    localparam int CNT_W = (CYCLE > 1) ? $clog2(CYCLE) : 1;
    localparam logic [CNT_W-1:0] MID_CNT = CNT_W'(CYCLE / 2 - 1);
    localparam logic [CNT_W-1:0] END_CNT = CNT_W'(CYCLE - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;

    // NOTE: every *_d gets a default before any branch, so no latch can be inferred.
    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (clear) begin
            cnt_d = '0;
            idx_d = '0;
        end else if (cnt_q == END_CNT) begin
            cnt_d = '0;
            if (bit_en) idx_d = idx_q + 3'd1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: state flops use non-blocking assignments only; blocking here would race other flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    assign mid_bit = !clear && (cnt_q == MID_CNT);
    assign end_bit = !clear && (cnt_q == END_CNT);
    assign bit_idx = idx_q;

endmodule

// File: rtl/uart_transceiver.sv
// 8N1 UART: independent receiver and transmitter with valid/ready byte interfaces.
module uart_transceiver
    import uart_pkg::*;
#(
    parameter int CLK_FRE   = 27,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_pin,
    output logic [7:0] rx_data,
    output logic       rx_data_valid,
    input  logic       rx_data_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_data_valid,
    output logic       tx_data_ready,
    output logic       tx_pin
);

    localparam int CYCLE = bit_cycles(CLK_FRE, BAUD_RATE);

    // ---------------- receiver ----------------
    rx_state_t  rx_state_q, rx_state_d;
    logic [1:0] rx_sync_q, rx_sync_d;
    logic       rx_prev_q, rx_prev_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_line, rx_fall, rx_mid, rx_end;
    logic [2:0] rx_idx;

    assign rx_line = rx_sync_q[1];
    assign rx_fall = rx_prev_q & ~rx_line;

    uart_bit_timer #(.CYCLE(CYCLE)) u_rx_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (rx_state_q == RX_IDLE || rx_state_q == RX_DATA),
        .bit_en  (rx_state_q == RX_REC_BYTE),
        .mid_bit (rx_mid),
        .end_bit (rx_end),
        .bit_idx (rx_idx)
    );

    always_comb begin
        rx_sync_d  = {rx_sync_q[0], rx_pin};
        rx_prev_d  = rx_line;
        rx_state_d = rx_state_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        case (rx_state_q)
            RX_IDLE:     if (rx_fall) rx_state_d = RX_START;
            RX_START: begin
                // A start bit that is high again at its centre was a glitch.
                if (rx_mid && rx_line) rx_state_d = RX_IDLE;
                else if (rx_end)       rx_state_d = RX_REC_BYTE;
            end
            RX_REC_BYTE: begin
                if (rx_mid) rx_shift_d = {rx_line, rx_shift_q[7:1]};
                if (rx_end && rx_idx == 3'd7) rx_state_d = RX_STOP;
            end
            RX_STOP: begin
                if (rx_mid) begin
                    if (rx_line) begin
                        rx_data_d  = rx_shift_q;
                        rx_state_d = RX_DATA;
                    end else begin
                        rx_state_d = RX_IDLE;
                    end
                end
            end
            RX_DATA:     if (rx_data_ready) rx_state_d = RX_IDLE;
            default:     rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q <= RX_IDLE;
            rx_sync_q  <= 2'b11;
            rx_prev_q  <= 1'b1;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_sync_q  <= rx_sync_d;
            rx_prev_q  <= rx_prev_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
        end
    end

    assign rx_data       = rx_data_q;
    assign rx_data_valid = (rx_state_q == RX_DATA);

    // ---------------- transmitter ----------------
    tx_state_t  tx_state_q, tx_state_d;
    logic [7:0] tx_byte_q, tx_byte_d;
    logic       tx_pin_q, tx_pin_d;
    logic       tx_mid, tx_end;
    logic [2:0] tx_idx;

    uart_bit_timer #(.CYCLE(CYCLE)) u_tx_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (tx_state_q == TX_IDLE),
        .bit_en  (tx_state_q == TX_SEND_BYTE),
        .mid_bit (tx_mid),
        .end_bit (tx_end),
        .bit_idx (tx_idx)
    );

    // Accepting in the last stop cycle keeps back-to-back frames gapless on the line.
    assign tx_data_ready = (tx_state_q == TX_IDLE) || (tx_state_q == TX_STOP && tx_end);

    always_comb begin
        tx_state_d = tx_state_q;
        tx_byte_d  = tx_byte_q;
        case (tx_state_q)
            TX_IDLE: begin
                if (tx_data_valid) begin
                    tx_byte_d  = tx_data;
                    tx_state_d = TX_START;
                end
            end
            TX_START:     if (tx_end) tx_state_d = TX_SEND_BYTE;
            TX_SEND_BYTE: if (tx_end && tx_idx == 3'd7) tx_state_d = TX_STOP;
            TX_STOP: begin
                if (tx_end) begin
                    if (tx_data_valid) begin
                        tx_byte_d  = tx_data;
                        tx_state_d = TX_START;
                    end else begin
                        tx_state_d = TX_IDLE;
                    end
                end
            end
            default:      tx_state_d = TX_IDLE;
        endcase

        case (tx_state_q)
            TX_START:     tx_pin_d = 1'b0;
            TX_SEND_BYTE: tx_pin_d = tx_byte_q[tx_idx];
            default:      tx_pin_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= TX_IDLE;
            tx_byte_q  <= '0;
            tx_pin_q   <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_byte_q  <= tx_byte_d;
            tx_pin_q   <= tx_pin_d;
        end
    end

    assign tx_pin = tx_pin_q;

    logic unused_tx_mid;
    assign unused_tx_mid = tx_mid;

endmodule

// File: tb/tb_uart_transceiver.sv
// Scoreboard bench for uart_transceiver: line-level decoder and byte queues as the reference.
module tb_uart_transceiver;

    localparam int CLK_FRE   = 1;
    localparam int BAUD_RATE = 100000;
    localparam int CYC       = CLK_FRE * 1_000_000 / BAUD_RATE;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       rx_drive = 1'b1;
    logic       loop_en = 1'b0;
    logic       rx_pin_w;
    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic       rx_data_ready = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_data_valid = 1'b0;
    logic       tx_data_ready;
    logic       tx_pin;

    int n_tests = 0;
    int n_fails = 0;
    int n_valid_cyc = 0;

    logic [7:0] rx_exp_q[$];
    logic [7:0] tx_exp_q[$];
    logic       tx_mon_en = 1'b1;
    logic [7:0] tx_mon_byte;

    logic       rec_pin [0:259];
    logic       rec_rdy [0:259];
    logic [7:0] t5_exp [0:1];
    int         s, low_len, match, hi_cnt, v0;
    logic [9:0] exp_bits;
    logic [7:0] dec, rb, tb_b;

    assign rx_pin_w = loop_en ? tx_pin : rx_drive;

    always #5 clk = ~clk;

    uart_transceiver #(.CLK_FRE(CLK_FRE), .BAUD_RATE(BAUD_RATE)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_pin        (rx_pin_w),
        .rx_data       (rx_data),
        .rx_data_valid (rx_data_valid),
        .rx_data_ready (rx_data_ready),
        .tx_data       (tx_data),
        .tx_data_valid (tx_data_valid),
        .tx_data_ready (tx_data_ready),
        .tx_pin        (tx_pin)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fails++;
        $display("FAIL %s", name);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Waits for the handshake with tx_data_valid already high; returns just after the accepting edge.
    task automatic accept_wait();
        int waited = 0;
        @(negedge clk);
        while (!tx_data_ready && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 300) fail_now("tx_accept_timeout");
        @(posedge clk);
        #1;
    endtask

    task automatic send_tx(input logic [7:0] b);
        tx_exp_q.push_back(b);
        tx_data       = b;
        tx_data_valid = 1'b1;
        accept_wait();
        tx_data_valid = 1'b0;
    endtask

    // Drives one serial frame on rx_drive, truncated after max_cyc clocks; line returns high.
    task automatic drive_rx_frame(input logic [7:0] b, input logic stop, input int max_cyc);
        logic [9:0] bits;
        int cyc = 0;
        bits = {stop, b, 1'b0};
        for (int k = 0; k < 10 && cyc < max_cyc; k++) begin
            rx_drive = bits[k];
            for (int c = 0; c < CYC && cyc < max_cyc; c++) begin
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        rx_drive = 1'b1;
    endtask

    task automatic drain(input int bound);
        int w = 0;
        while ((rx_exp_q.size() != 0 || tx_exp_q.size() != 0) && w < bound) begin
            @(negedge clk);
            w++;
        end
        check("rx_queue_drained", 32'(rx_exp_q.size()), 32'd0);
        check("tx_queue_drained", 32'(tx_exp_q.size()), 32'd0);
    endtask

    function automatic int first_low(input int n);
        for (int i = 0; i < n; i++) if (rec_pin[i] === 1'b0) return i;
        return -1;
    endfunction

    // RX sink monitor: every accepted byte is matched against the expected queue.
    initial begin : rx_monitor
        forever begin
            @(negedge clk);
            if (rst_n && rx_data_valid) n_valid_cyc++;
            if (rst_n && rx_data_valid && rx_data_ready) begin
                if (rx_exp_q.size() == 0) begin
                    n_tests++;
                    n_fails++;
                    $display("FAIL rx_unexpected_byte: actual %0h required none", rx_data);
                end else begin
                    check("rx_byte", 32'(rx_data), 32'(rx_exp_q.pop_front()));
                end
            end
        end
    end

    // TX line monitor: decodes 8N1 frames from tx_pin by sampling bit centres.
    initial begin : tx_monitor
        forever begin
            @(negedge clk);
            if (tx_mon_en && rst_n && tx_pin === 1'b0) begin
                repeat (CYC / 2 - 1) @(negedge clk);
                check("tx_start_bit", 32'(tx_pin), 32'd0);
                for (int k = 0; k < 8; k++) begin
                    repeat (CYC) @(negedge clk);
                    tx_mon_byte[k] = tx_pin;
                end
                repeat (CYC) @(negedge clk);
                check("tx_stop_bit", 32'(tx_pin), 32'd1);
                if (tx_exp_q.size() == 0) begin
                    n_tests++;
                    n_fails++;
                    $display("FAIL tx_unexpected_frame: actual %0h required none", tx_mon_byte);
                end else begin
                    check("tx_byte", 32'(tx_mon_byte), 32'(tx_exp_q.pop_front()));
                end
            end
        end
    end

    initial begin : watchdog
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        // Reset values
        #2 rst_n = 1'b0;
        #21;
        check("rst_tx_pin", 32'(tx_pin), 32'd1);
        check("rst_tx_ready", 32'(tx_data_ready), 32'd1);
        check("rst_rx_valid", 32'(rx_data_valid), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'h00);
        @(negedge clk) rst_n = 1'b1;
        tick(3);

        // 1. Single 8'h55 frame, valid for one cycle; tx_data changes after acceptance
        check("t1_ready_idle", 32'(tx_data_ready), 32'd1);
        tx_exp_q.push_back(8'h55);
        tx_data       = 8'h55;
        tx_data_valid = 1'b1;
        tick(1);
        tx_data_valid = 1'b0;
        tx_data       = 8'hFF;
        for (int i = 0; i < 140; i++) begin
            @(negedge clk);
            rec_pin[i] = tx_pin;
            rec_rdy[i] = tx_data_ready;
        end
        s = first_low(140);
        check("t1_start_seen_early", 32'(s >= 0 && s <= 20), 32'd1);
        low_len = 0;
        while (low_len < 140 && rec_rdy[low_len] == 1'b0) low_len++;
        check("t1_ready_low_len_in_range", 32'(low_len >= 10 * CYC - 1 && low_len <= 10 * CYC), 32'd1);
        if (s >= 0 && s <= 20) begin
            exp_bits = {1'b1, 8'h55, 1'b0};
            for (int k = 0; k < 10; k++) begin
                match = 0;
                for (int c = 0; c < CYC; c++)
                    if (rec_pin[s + k * CYC + c] === exp_bits[k]) match++;
                check($sformatf("t1_bit%0d_samples", k), 32'(match), 32'(CYC));
            end
            hi_cnt = 0;
            for (int i = s + 10 * CYC; i < s + 10 * CYC + 20; i++) if (rec_pin[i] === 1'b1) hi_cnt++;
            check("t1_idle_after", 32'(hi_cnt), 32'd20);
        end
        tick(5);

        // 2. Loopback: 8'hA5 then random bytes
        loop_en       = 1'b1;
        rx_data_ready = 1'b1;
        v0            = n_valid_cyc;
        rx_exp_q.push_back(8'hA5);
        send_tx(8'hA5);
        for (int i = 0; i < 4; i++) begin
            tb_b = 8'($urandom);
            rx_exp_q.push_back(tb_b);
            send_tx(tb_b);
        end
        drain(2000);
        check("t2_valid_one_cycle_each", 32'(n_valid_cyc - v0), 32'd5);
        tick(5);
        loop_en = 1'b0;
        tick(5);

        // 3. Held byte with ready low; overrun frame ignored
        rx_data_ready = 1'b0;
        rx_exp_q.push_back(8'h3C);
        drive_rx_frame(8'h3C, 1'b1, 1000);
        tick(5);
        check("t3_valid_held", 32'(rx_data_valid), 32'd1);
        check("t3_data_held", 32'(rx_data), 32'h3C);
        drive_rx_frame(8'hFF, 1'b1, 1000);
        tick(20);
        check("t3_valid_after_overrun", 32'(rx_data_valid), 32'd1);
        check("t3_data_after_overrun", 32'(rx_data), 32'h3C);
        rx_data_ready = 1'b1;
        @(negedge clk);
        check("t3_valid_at_accept", 32'(rx_data_valid), 32'd1);
        @(negedge clk);
        check("t3_valid_drops", 32'(rx_data_valid), 32'd0);
        check("t3_data_kept", 32'(rx_data), 32'h3C);
        tick(5);

        // 4. Glitch reject and framing error, then recovery
        v0 = n_valid_cyc;
        rx_drive = 1'b0;
        tick(3);
        rx_drive = 1'b1;
        tick(40);
        check("t4_glitch_no_valid", 32'(n_valid_cyc - v0), 32'd0);
        drive_rx_frame(8'h12, 1'b0, 1000);
        tick(30);
        check("t4_framing_no_valid", 32'(n_valid_cyc - v0), 32'd0);
        rb = 8'($urandom);
        rx_exp_q.push_back(rb);
        drive_rx_frame(rb, 1'b1, 1000);
        drain(300);

        // 5. Back-to-back frames with valid held high
        t5_exp[0] = 8'h01;
        t5_exp[1] = 8'h80;
        tx_exp_q.push_back(8'h01);
        tx_exp_q.push_back(8'h80);
        fork
            begin
                for (int i = 0; i < 240; i++) begin
                    @(negedge clk);
                    rec_pin[i] = tx_pin;
                end
            end
            begin
                tx_data       = 8'h01;
                tx_data_valid = 1'b1;
                accept_wait();
                tx_data = 8'h80;
                accept_wait();
                tx_data_valid = 1'b0;
            end
        join
        s = first_low(240);
        check("t5_start_seen_early", 32'(s >= 0 && s <= 30), 32'd1);
        if (s >= 0 && s <= 30) begin
            for (int f = 0; f < 2; f++) begin
                for (int k = 0; k < 8; k++)
                    dec[k] = rec_pin[s + f * 10 * CYC + (k + 1) * CYC + CYC / 2];
                check("t5_byte", 32'(dec), 32'(t5_exp[f]));
                check("t5_start", 32'(rec_pin[s + f * 10 * CYC + CYC / 2]), 32'd0);
                check("t5_stop", 32'(rec_pin[s + f * 10 * CYC + 9 * CYC + CYC / 2]), 32'd1);
            end
            check("t5_stop_ends_at_100", 32'(rec_pin[s + 10 * CYC - 1]), 32'd1);
            check("t5_next_start_at_100", 32'(rec_pin[s + 10 * CYC]), 32'd0);
            hi_cnt = 0;
            for (int i = s + 20 * CYC; i < 240; i++) if (rec_pin[i] === 1'b1) hi_cnt++;
            check("t5_idle_after_two", 32'(hi_cnt), 32'(240 - (s + 20 * CYC)));
        end
        drain(300);
        tick(5);

        // 6. Reset in the middle of bit 4 on both TX and RX
        tx_mon_en = 1'b0;
        rb   = 8'($urandom);
        tb_b = 8'($urandom);
        fork
            begin
                tx_data       = tb_b;
                tx_data_valid = 1'b1;
                tick(1);
                tx_data_valid = 1'b0;
            end
            begin
                drive_rx_frame(rb, 1'b1, 5 * CYC + CYC / 2);
            end
        join
        v0 = n_valid_cyc;
        #2 rst_n = 1'b0;
        #1;
        check("t6_tx_pin_reset", 32'(tx_pin), 32'd1);
        check("t6_tx_ready_reset", 32'(tx_data_ready), 32'd1);
        check("t6_rx_valid_reset", 32'(rx_data_valid), 32'd0);
        check("t6_rx_data_reset", 32'(rx_data), 32'h00);
        tick(3);
        @(negedge clk) rst_n = 1'b1;
        tx_mon_en = 1'b1;
        tick(30);
        check("t6_no_partial_byte", 32'(n_valid_cyc - v0), 32'd0);
        rb   = 8'($urandom);
        tb_b = 8'($urandom);
        rx_exp_q.push_back(rb);
        fork
            drive_rx_frame(rb, 1'b1, 1000);
            send_tx(tb_b);
        join
        drain(400);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

endmodule
